// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between the ALU control decode (master) and the
// sequential binary-to-BCD converter (slave).
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 6,
  parameter int DIGITS = 2
);
  logic                  init;
  logic [BIN_W-1:0]      bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  done;
  logic                  busy;
  logic                  ovf;

  modport master (output init, bin, input bcd, done, busy, ovf);
  modport slave  (input init, bin, output bcd, done, busy, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double dabble) binary-to-BCD converter.
// Optional leading-zero blanking (4'hF) when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq #(
  parameter int BIN_W  = 6,
  parameter int DIGITS = 2
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int W     = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sticky;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;
  logic               r_done;
  logic               w_busy;
  logic               w_capture;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_bcd_out;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next    = r_state;
    w_busy    = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.init) begin
          w_capture = 1'b1;
          w_next    = SHIFT;
        end
      end
      SHIFT: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_W'(BIN_W - 1)) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // All nibbles are adjusted in parallel from the current register value.
  always_comb begin
    w_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_work[BIN_W+4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_work[BIN_W+4*d +: 4] + 4'd3;
      else                                w_adj[4*d +: 4] = r_work[BIN_W+4*d +: 4];
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic w_lead;

  // Blank zeros from the top digit down until the first nonzero; digit 0 stays.
  always_comb begin
    w_bcd_out = r_work[W-1:BIN_W];
    w_lead    = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (w_lead && (w_bcd_out[4*d +: 4] == 4'd0)) w_bcd_out[4*d +: 4] = 4'hF;
      else                                         w_lead = 1'b0;
    end
  end
`else
  assign w_bcd_out = r_work[W-1:BIN_W];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_work   <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      r_bcd    <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_work   <= {{BCD_W{1'b0}}, bus.bin};
            r_cnt    <= '0;
            r_sticky <= 1'b0;
          end
        end
        SHIFT: begin
          // The bit leaving the top nibble is a lost decimal carry.
          r_work   <= {w_adj[BCD_W-2:0], r_work[BIN_W-1:0], 1'b0};
          r_sticky <= r_sticky | w_adj[BCD_W-1];
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          r_bcd  <= w_bcd_out;
          r_ovf  <= r_sticky;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.bcd  = r_bcd;
  assign bus.ovf  = r_ovf;
  assign bus.done = r_done;
  assign bus.busy = w_busy;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 6-bit and a 7-bit instance, predicted
// from decimal arithmetic and the documented handshake timing.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(6), .DIGITS(2)) bus0 ();
  bin2bcd_seq_if #(.BIN_W(7), .DIGITS(2)) bus1 ();

  bin2bcd_seq #(.BIN_W(6), .DIGITS(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  bin2bcd_seq #(.BIN_W(7), .DIGITS(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic       init_a [2];
  logic [6:0] bin_a  [2];
  logic [7:0] bcd_a  [2];
  logic       done_a [2];
  logic       busy_a [2];
  logic       ovf_a  [2];

  assign bus0.init = init_a[0];
  assign bus0.bin  = bin_a[0][5:0];
  assign bus1.init = init_a[1];
  assign bus1.bin  = bin_a[1];
  assign bcd_a[0]  = bus0.bcd;
  assign bcd_a[1]  = bus1.bcd;
  assign done_a[0] = bus0.done;
  assign done_a[1] = bus1.done;
  assign busy_a[0] = bus0.busy;
  assign busy_a[1] = bus1.busy;
  assign ovf_a[0]  = bus0.ovf;
  assign ovf_a[1]  = bus1.ovf;

  typedef struct {
    int         k;
    logic [7:0] bcd;
    logic       ovf;
    int         due;
  } item_t;

  item_t      q[$];
  int         cyc = 0;
  int         next_free [2] = '{0, 0};
  logic [7:0] hold_bcd  [2] = '{8'h00, 8'h00};
  logic       hold_ovf  [2] = '{1'b0, 1'b0};
  int         checks = 0;
  int         errors = 0;

  function automatic int bw(int k);
    return (k == 0) ? 6 : 7;
  endfunction

  // Reference: decimal value modulo 100, split into two digits.
  function automatic item_t model(int k, int v, int due);
    item_t it;
    int r, d1, d0;
    r  = v % 100;
    d1 = r / 10;
    d0 = r % 10;
`ifdef BIN2BCD_BLANK_EN
    if (d1 == 0) d1 = 15;
`endif
    it.k   = k;
    it.bcd = 8'(d1 * 16 + d0);
    it.ovf = (v >= 100);
    it.due = due;
    return it;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Predictor: a request is accepted when init is high and the block is free.
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst && init_a[k] && cyc >= next_free[k]) begin
        q.push_back(model(k, int'(bin_a[k]), cyc + bw(k) + 1));
        next_free[k] = cyc + bw(k) + 2;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard between edges.
  always @(negedge clk) begin : monitor
    int   idx;
    logic exp_busy;
    for (int k = 0; k < 2; k++) begin
      idx      = -1;
      exp_busy = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].k == k) begin
          if (idx < 0) idx = i;
          if (cyc >= q[i].due - bw(k) - 1 && cyc <= q[i].due - 2) exp_busy = 1'b1;
        end
      end
      if (done_a[k]) begin
        if (idx >= 0 && q[idx].due == cyc) begin
          check($sformatf("dut%0d bcd", k), 32'(bcd_a[k]), 32'(q[idx].bcd));
          check($sformatf("dut%0d ovf", k), 32'(ovf_a[k]), 32'(q[idx].ovf));
          hold_bcd[k] = q[idx].bcd;
          hold_ovf[k] = q[idx].ovf;
          q.delete(idx);
        end else begin
          check($sformatf("dut%0d unexpected done", k), 32'(done_a[k]), 32'd0);
        end
      end else if (idx >= 0 && q[idx].due <= cyc) begin
        check($sformatf("dut%0d missing done", k), 32'(done_a[k]), 32'd1);
        q.delete(idx);
      end
      check($sformatf("dut%0d busy", k), 32'(busy_a[k]), 32'(exp_busy));
      check($sformatf("dut%0d bcd hold", k), 32'(bcd_a[k]), 32'(hold_bcd[k]));
      check($sformatf("dut%0d ovf hold", k), 32'(ovf_a[k]), 32'(hold_ovf[k]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input int k, input int v);
    bin_a[k]  = 7'(v);
    init_a[k] = 1'b1;
    step(1);
    init_a[k] = 1'b0;
    step(bw(k) + 3);
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    q.delete();
    next_free = '{0, 0};
    hold_bcd  = '{8'h00, 8'h00};
    hold_ovf  = '{1'b0, 1'b0};
  endtask

  initial begin
    init_a = '{1'b1, 1'b0};
    bin_a  = '{7'd37, 7'd0};
    step(3);
    check("reset bcd", 32'(bcd_a[0]), 32'h00);
    check("reset done", 32'(done_a[0]), 32'd0);
    check("reset busy", 32'(busy_a[0]), 32'd0);
    check("reset ovf", 32'(ovf_a[0]), 32'd0);
    rst = 1'b1;
    step(1);
    init_a[0] = 1'b0;
    step(10);

    pulse(0, 49);
    step(4);
    foreach (bin_a[i]) ;
    pulse(0, 0);
    pulse(0, 63);
    pulse(0, 9);
    pulse(0, 10);
    pulse(0, 7);
    pulse(0, 40);

    // Continuous mode with a mid-conversion input change.
    bin_a[0]  = 7'd5;
    init_a[0] = 1'b1;
    step(3);
    bin_a[0]  = 7'd12;
    step(14);
    init_a[0] = 1'b0;
    step(12);

    pulse(1, 100);
    pulse(1, 127);
    pulse(1, 99);

    for (int n = 0; n < 40; n++) begin
      bin_a[0]  = 7'($urandom_range(0, 63));
      bin_a[1]  = 7'($urandom_range(0, 127));
      init_a[0] = 1'b1;
      init_a[1] = ($urandom_range(0, 1) == 1);
      for (int c = $urandom_range(1, 12); c > 0; c--) begin
        step(1);
        if ($urandom_range(0, 3) == 0) bin_a[0] = 7'($urandom_range(0, 63));
        if ($urandom_range(0, 3) == 0) bin_a[1] = 7'($urandom_range(0, 127));
      end
      init_a[0] = 1'b0;
      init_a[1] = 1'b0;
      step($urandom_range(0, 10));
    end
    step(12);

    // Reset in the middle of a conversion: outputs clear at once, no done later.
    bin_a[0]  = 7'd45;
    init_a[0] = 1'b1;
    step(1);
    init_a[0] = 1'b0;
    step(3);
    assert_reset();
    #1;
    check("midreset bcd", 32'(bcd_a[0]), 32'h00);
    check("midreset busy", 32'(busy_a[0]), 32'd0);
    check("midreset done", 32'(done_a[0]), 32'd0);
    check("midreset ovf", 32'(ovf_a[1]), 32'd0);
    step(2);
    rst = 1'b1;
    step(15);

    check("scoreboard drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
